arbitrated_fifos_hs: RTL

//  N input FIFOs drained by an integrated arbiter into one registered valid/ready output.

---
 rtl/arb_fifo_pkg.sv | 16 +
 rtl/arbitrated_fifos_hs_if.sv | 37 +++
 rtl/arb_fifo_chan.sv | 54 +++++
 rtl/arbitrated_fifos_hs.sv | 132 +++++++++++++
 4 files changed

// File: rtl/arb_fifo_pkg.sv
// Shared constants and width helpers for the arbitrated FIFO block.
package arb_fifo_pkg;

    localparam int unsigned MODE_RR = 0;
    localparam int unsigned MODE_WQ = 1;
    localparam int unsigned MODE_SP = 2;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arbitrated_fifos_hs_if.sv
// Producer/consumer-facing signal bundle of arbitrated_fifos_hs.
interface arbitrated_fifos_hs_if #(
    parameter int unsigned NUM_REQS = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned QWID     = 4
);
    import arb_fifo_pkg::*;

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned IW = idx_width(NUM_REQS);

    logic [NUM_REQS-1:0]       push;
    logic [NUM_REQS-1:0]       reqs;
    logic [NUM_REQS*WIDTH-1:0] flat_data_in;
    logic [NUM_REQS*QWID-1:0]  quantums;
    logic [NUM_REQS-1:0]       empty;
    logic [NUM_REQS-1:0]       full;
    logic [NUM_REQS-1:0]       overflow;
    logic [NUM_REQS*CW-1:0]    flat_count;
    logic [NUM_REQS-1:0]       gnt;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic [IW-1:0]             out_chan;

    modport master (
        output push, reqs, flat_data_in, quantums, out_ready,
        input  empty, full, overflow, flat_count, gnt, out_valid, out_data, out_chan
    );

    modport slave (
        input  push, reqs, flat_data_in, quantums, out_ready,
        output empty, full, overflow, flat_count, gnt, out_valid, out_data, out_chan
    );

endinterface

// File: rtl/arb_fifo_chan.sv
// One channel FIFO: storage, wrapping pointers, occupancy and sticky overflow.
module arb_fifo_chan
    import arb_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic [CW-1:0]    count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic             wr_en;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    assign wr_en    = push & (~full | pop);
    assign rdata    = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(wr_en) - CW'(pop);
            if (push & full & ~pop) overflow_q <= 1'b1;
        end
    end

endmodule

// File: rtl/arbitrated_fifos_hs.sv
// Per-channel FIFOs drained by a RR / weighted-quantum / strict-priority arbiter
// into a single registered valid/ready output.
module arbitrated_fifos_hs
    import arb_fifo_pkg::*;
#(
    parameter int unsigned NUM_REQS = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned QWID     = 4,
    parameter int unsigned MODE     = MODE_RR
) (
    input logic                  clk,
    input logic                  rst,
    arbitrated_fifos_hs_if.slave bus
);
    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned IW = idx_width(NUM_REQS);

    logic [NUM_REQS-1:0] empty, full, overflow, eligible, gnt;
    logic [WIDTH-1:0]    rdata [NUM_REQS];
    logic [CW-1:0]       count [NUM_REQS];

    logic [IW-1:0]   ptr_q, ptr_d, win;
    logic [QWID-1:0] credit_q, credit_d, quantum;
    logic            out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [IW-1:0]   out_chan_q, out_chan_d;
    logic            slot_free, grant, hold;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_chan
        arb_fifo_chan #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .CW    (CW)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .push     (bus.push[i]),
            .pop      (gnt[i]),
            .wdata    (bus.flat_data_in[i*WIDTH +: WIDTH]),
            .rdata    (rdata[i]),
            .empty    (empty[i]),
            .full     (full[i]),
            .overflow (overflow[i]),
            .count    (count[i])
        );
    end

    // Nearest eligible channel after ptr, wrapping; descending scan so the closest wins.
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQS-1:0] elig,
                                              input logic [IW-1:0] ptr);
        int unsigned c;
        rr_pick = ptr;
        for (int k = NUM_REQS; k >= 1; k--) begin
            c = (int'(ptr) + k) % NUM_REQS;
            if (elig[c]) rr_pick = IW'(c);
        end
    endfunction

    function automatic logic [IW-1:0] sp_pick(input logic [NUM_REQS-1:0] elig);
        sp_pick = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            if (elig[k]) sp_pick = IW'(k);
        end
    endfunction

    assign eligible  = bus.reqs & ~empty;
    assign slot_free = ~out_valid_q | bus.out_ready;
    assign grant     = slot_free & (|eligible);
    assign hold      = (MODE == MODE_WQ) && eligible[ptr_q] && (credit_q != '0);

    always_comb begin
        win         = '0;
        ptr_d       = ptr_q;
        credit_d    = credit_q;
        quantum     = '0;
        gnt         = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;

        if (MODE == MODE_SP) win = sp_pick(eligible);
        else if (hold)       win = ptr_q;
        else                 win = rr_pick(eligible, ptr_q);

        if (grant) begin
            gnt[win]    = 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = rdata[win];
            out_chan_d  = win;
            if (MODE != MODE_SP) ptr_d = win;
            if (MODE == MODE_WQ) begin
                quantum = bus.quantums[win*QWID +: QWID];
                if (hold)                credit_d = credit_q - QWID'(1);
                else if (quantum == '0)  credit_d = '0;
                else                     credit_d = quantum - QWID'(1);
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= IW'(NUM_REQS - 1);
            credit_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            credit_q    <= credit_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    always_comb begin
        bus.flat_count = '0;
        for (int i = 0; i < NUM_REQS; i++) bus.flat_count[i*CW +: CW] = count[i];
    end

    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.overflow  = overflow;
    assign bus.gnt       = gnt;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;

endmodule
